// File: rtl/vram_arb_pkg.sv
// Shared types and defaults for the video-RAM arbiter.
package vram_arb_pkg;

    // Default geometry: 8K words of 32 bits, four posted writes.
    localparam int unsigned DefAddrW     = 13;
    localparam int unsigned DefDataW     = 32;
    localparam int unsigned DefFifoDepth = 4;

    // CPU read sequencer: issue in StIdle, capture in StRdData, release in StRdDone.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRdData = 2'd1,
        StRdDone = 2'd2
    } rd_state_e;

    // One posted CPU write at the default geometry.
    typedef struct packed {
        logic [DefAddrW-1:0] addr;
        logic [DefDataW-1:0] data;
    } fifo_entry_t;

    // Width of a packed {addr, data} posting entry for arbitrary geometry.
    function automatic int unsigned entry_width(input int unsigned addr_w,
                                                input int unsigned data_w);
        return addr_w + data_w;
    endfunction

endpackage

// File: rtl/wr_post_fifo.sv
// Synchronous write-posting FIFO. DEPTH must be a power of two so the
// pointers wrap naturally; the occupancy counter spans 0..DEPTH.
module wr_post_fifo #(
    parameter int unsigned WIDTH = 45,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned     PtrW      = $clog2(DEPTH);
    localparam logic [PtrW:0]   CountFull = (PtrW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW:0]    count_q;

    // Pointer and occupancy bookkeeping; reset drops any pending entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Status flags and head-of-queue view.
    always_comb begin
        full  = (count_q == CountFull);
        empty = (count_q == '0);
        head  = mem_q[rd_ptr_q];
    end

    // The caller guarantees it never overfills or underflows the queue.
    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: VGA scan-out has absolute priority, then a
// pending CPU read issue, then the CPU write-posting FIFO drain.
// The VRAM has a one-cycle synchronous read, so the address for a granted
// access is driven combinationally in the grant cycle and the data appears
// on ram_rdata in the next cycle.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = DefAddrW,
    parameter int unsigned DATA_W     = DefDataW,
    parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_we,
    input  logic              cpu_re,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hold,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_valid,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned EntryW = entry_width(ADDR_W, DATA_W);

    rd_state_e         state_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic              vga_valid_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;

    logic              rd_req;
    logic              vga_gnt;
    logic              rd_issue;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [EntryW-1:0] fifo_head;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    wr_post_fifo #(
        .WIDTH (EntryW),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_post_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({cpu_addr, cpu_wdata}),
        .pop   (fifo_pop),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Grant decision and CPU stall. A simultaneous write and read strobe is
    // treated as a write only. Full is sampled at cycle start, so a drain in
    // the same cycle does not admit the push until the following cycle.
    // Reads only issue once the FIFO is empty, which keeps read-after-write
    // consistent without address comparison.
    always_comb begin
        head_addr = fifo_head[EntryW-1:DATA_W];
        head_data = fifo_head[DATA_W-1:0];
        rd_req    = cpu_re & ~cpu_we;
        // The slot after a read issue is reserved for the capture cycle.
        vga_gnt   = ~rst & vga_req & (state_q != StRdData);
        rd_issue  = ~rst & rd_req & (state_q == StIdle) & fifo_empty & ~vga_req;
        fifo_pop  = ~rst & ~fifo_empty & ~vga_gnt & ~rd_issue;
        fifo_push = ~rst & cpu_we & ~fifo_full;
        cpu_hold  = ~rst & ((rd_req & (state_q != StRdDone)) | (cpu_we & fifo_full));
    end

    // VRAM port mux; an idle cycle keeps the last address and write data.
    always_comb begin
        ram_addr  = ram_addr_q;
        ram_wdata = ram_wdata_q;
        ram_we    = fifo_pop;
        if (vga_gnt) begin
            ram_addr = vga_addr;
        end else if (rd_issue) begin
            ram_addr = cpu_addr;
        end else if (fifo_pop) begin
            ram_addr  = head_addr;
            ram_wdata = head_data;
        end
    end

    // Remember the last driven address and write data for idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            ram_addr_q  <= ram_addr;
            ram_wdata_q <= ram_wdata;
        end
    end

    // Read sequencer with registered read data and VGA valid strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cpu_rdata_q <= '0;
            vga_valid_q <= 1'b0;
        end else begin
            vga_valid_q <= vga_gnt;
            case (state_q)
                StIdle: begin
                    if (rd_issue) begin
                        state_q <= StRdData;
                    end
                end
                StRdData: begin
                    cpu_rdata_q <= ram_rdata;
                    state_q     <= StRdDone;
                end
                // The strobe still high here is the same load; do not reissue.
                StRdDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Output drive; scan-out data is the raw VRAM output in the valid cycle.
    always_comb begin
        cpu_rdata = cpu_rdata_q;
        vga_valid = vga_valid_q;
        vga_rdata = ram_rdata;
    end

    // Exactly one access source per cycle.
    a_one_grant: assert property (@(posedge clk) disable iff (rst)
        !(ram_we && (vga_gnt || rd_issue)));
    a_no_issue_on_vga: assert property (@(posedge clk) disable iff (rst)
        !(vga_gnt && rd_issue));

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: a behavioural VRAM, queues of expected
// VRAM writes and VGA read data, and per-transaction hold-cycle checks.
module tb_vram_arbiter;
    import vram_arb_pkg::*;

    localparam int unsigned AW = DefAddrW;
    localparam int unsigned DW = DefDataW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_we = 1'b0;
    logic          cpu_re = 1'b0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_hold;
    logic          vga_req = 1'b0;
    logic [AW-1:0] vga_addr = '0;
    logic [DW-1:0] vga_rdata;
    logic          vga_valid;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata = '0;

    always #5 clk = ~clk;

    vram_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_rdata (cpu_rdata),
        .cpu_hold  (cpu_hold),
        .vga_req   (vga_req),
        .vga_addr  (vga_addr),
        .vga_rdata (vga_rdata),
        .vga_valid (vga_valid),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    // Unwritten locations read back a fixed address-derived pattern.
    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return 32'hC0DE_0000 | DW'(a);
    endfunction

    // Behavioural VRAM with one-cycle synchronous read.
    logic [DW-1:0] mem [1 << AW];
    bit            mem_wr [1 << AW];
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr]    <= ram_wdata;
            mem_wr[ram_addr] <= 1'b1;
        end
        ram_rdata <= mem_wr[ram_addr] ? mem[ram_addr] : pat(ram_addr);
    end

    typedef struct {
        fifo_entry_t e;
        int          cyc;
        bit          strict;
    } wr_exp_t;

    wr_exp_t       wr_q[$];
    logic [DW-1:0] vga_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    bit            strict_lat = 1'b0;
    bit            mon_on = 1'b0;
    logic          exp_vv = 1'b0;
    wr_exp_t       mon_x;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: VGA valid timing, VGA data and VRAM write order.
    always @(negedge clk) begin
        if (mon_on) begin
            check_eq("vga_valid", vga_valid, exp_vv);
            if (vga_valid) begin
                if (vga_q.size() == 0) check_eq("vga_unexpected", 1, 0);
                else check_eq("vga_rdata", vga_rdata, vga_q.pop_front());
            end
            if (ram_we) begin
                if (wr_q.size() == 0) begin
                    check_eq("ram_we_unexpected", 1, 0);
                end else begin
                    mon_x = wr_q.pop_front();
                    check_eq("wr_addr", ram_addr, mon_x.e.addr);
                    check_eq("wr_data", ram_wdata, mon_x.e.data);
                    if (mon_x.strict) check_eq("wr_lat", cyc - mon_x.cyc, 1);
                    else check_eq("wr_after_push", cyc > mon_x.cyc, 1);
                end
            end
        end
        exp_vv <= vga_req & ~rst;
    end

    // All stimulus tasks start and end at posedge + 1.
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input int exp_hold, input string tag);
        int      n;
        bit      done;
        wr_exp_t x;
        n = 0;
        done = 1'b0;
        cpu_we = 1'b1;
        cpu_addr = a;
        cpu_wdata = d;
        while (!done) begin
            @(negedge clk);
            if (!cpu_hold) begin
                x.e.addr = a;
                x.e.data = d;
                x.cyc = cyc;
                x.strict = strict_lat;
                wr_q.push_back(x);
                done = 1'b1;
            end else if (n >= 32) begin
                check_eq({tag, "_timeout"}, 1, 0);
                done = 1'b1;
            end else begin
                n++;
            end
            @(posedge clk);
            #1;
        end
        cpu_we = 1'b0;
        check_eq({tag, "_hold"}, n, exp_hold);
    endtask

    task automatic cpu_read(input logic [AW-1:0] a, input logic [DW-1:0] exp_d,
                            input int exp_hold, input string tag);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        cpu_re = 1'b1;
        cpu_addr = a;
        while (!done) begin
            @(negedge clk);
            if (!cpu_hold) begin
                check_eq({tag, "_data"}, cpu_rdata, exp_d);
                done = 1'b1;
            end else if (n >= 32) begin
                check_eq({tag, "_timeout"}, 1, 0);
                done = 1'b1;
            end else begin
                n++;
            end
            @(posedge clk);
            #1;
        end
        cpu_re = 1'b0;
        check_eq({tag, "_hold"}, n, exp_hold);
    endtask

    task automatic vga_burst(input logic [AW-1:0] a0, input int n);
        for (int i = 0; i < n; i++) begin
            vga_req = 1'b1;
            vga_addr = a0 + AW'(i);
            vga_q.push_back(pat(a0 + AW'(i)));
            @(posedge clk);
            #1;
        end
        vga_req = 1'b0;
    endtask

    initial begin
        // Reset with read and scan-out requests pending.
        cpu_re = 1'b1;
        vga_req = 1'b1;
        vga_addr = 13'h100;
        cpu_addr = 13'h040;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("rst_hold", cpu_hold, 0);
            check_eq("rst_ram_we", ram_we, 0);
            check_eq("rst_vga_valid", vga_valid, 0);
            check_eq("rst_ram_addr", ram_addr, 0);
            check_eq("rst_cpu_rdata", cpu_rdata, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cpu_re = 1'b0;
        vga_req = 1'b0;
        mon_on = 1'b1;
        cpu_read(13'h040, pat(13'h040), 2, "rd_after_rst");

        // Posted writes on consecutive cycles, each drained the next cycle.
        strict_lat = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_write(13'h010 + AW'(i), 32'hA0 + DW'(i), 0, "post");
        end
        idle(3);
        check_eq("post_drained", wr_q.size(), 0);
        cpu_read(13'h012, 32'hA2, 2, "post_rd");

        // Fill the FIFO while scan-out owns the port.
        strict_lat = 1'b0;
        fork
            vga_burst(13'h100, 6);
            begin
                for (int i = 0; i < 4; i++) begin
                    cpu_write(13'h030 + AW'(i), 32'hB0 + DW'(i), 0, "full_pre");
                end
                cpu_write(13'h034, 32'hB4, 3, "full_5th");
            end
        join
        idle(6);
        check_eq("full_drained", wr_q.size(), 0);
        check_eq("full_vga_done", vga_q.size(), 0);

        // Read-after-write.
        strict_lat = 1'b1;
        cpu_write(13'h020, 32'h1234, 0, "raw_wr");
        cpu_read(13'h020, 32'h1234, 3, "raw_rd");

        // Read delayed by two scan-out cycles.
        fork
            cpu_read(13'h050, pat(13'h050), 4, "rd_vga");
            vga_burst(13'h200, 2);
        join
        check_eq("rd_vga_done", vga_q.size(), 0);

        // Reset in the capture cycle of a read.
        cpu_re = 1'b1;
        cpu_addr = 13'h060;
        @(negedge clk);
        check_eq("mr_issue_hold", cpu_hold, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("mr_rst_hold", cpu_hold, 0);
        check_eq("mr_rst_ram_we", ram_we, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cpu_re = 1'b0;
        @(negedge clk);
        check_eq("mr_discard", cpu_rdata, 0);
        check_eq("mr_idle_hold", cpu_hold, 0);
        @(posedge clk);
        #1;
        cpu_read(13'h061, pat(13'h061), 2, "mr_fresh");

        // Writes stuck behind scan-out are dropped by reset.
        vga_req = 1'b1;
        vga_addr = 13'h300;
        vga_q.push_back(pat(13'h300));
        cpu_we = 1'b1;
        cpu_addr = 13'h070;
        cpu_wdata = 32'hD0;
        @(negedge clk);
        check_eq("disc_wr0_hold", cpu_hold, 0);
        @(posedge clk);
        #1;
        vga_addr = 13'h301;
        vga_q.push_back(pat(13'h301));
        cpu_addr = 13'h071;
        cpu_wdata = 32'hD1;
        @(negedge clk);
        check_eq("disc_wr1_hold", cpu_hold, 0);
        @(posedge clk);
        #1;
        cpu_we = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_eq("disc_rst_ram_we", ram_we, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        vga_req = 1'b0;
        idle(4);
        cpu_read(13'h070, pat(13'h070), 2, "disc_rd");

        idle(2);
        check_eq("end_wr_q", wr_q.size(), 0);
        check_eq("end_vga_q", vga_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video-RAM arbiter between the single-cycle CPU (`wvram`/`rvram` strobes) and the VGA scan-out reader. The VGA reader has absolute priority. CPU writes go into a small posting FIFO so the CPU normally runs without stalling. CPU reads freeze the CPU through `cpu_hold` until their data returns. The block sits between the CPU's VRAM decode and the VRAM block, which has a one-cycle synchronous read.

## Interface
- `ADDR_W`, 13: VRAM word-address width. The CPU supplies `m_addr[ADDR_W+1:2]`.
- `DATA_W`, 32: data width.
- `FIFO_DEPTH`, 4: number of write-posting entries. Must be a power of two, at least 2.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous reset, active-high
- `cpu_addr`  in  ADDR_W  CPU word address
- `cpu_wdata`  in  DATA_W  CPU store data
- `cpu_we`  in  1  CPU VRAM write strobe (`wvram`)
- `cpu_re`  in  1  CPU VRAM read strobe (`rvram`)
- `cpu_rdata`  out  DATA_W  read data; valid in the cycle `cpu_hold` falls
- `cpu_hold`  out  1  combinational stall; gates PC and regfile update
- `vga_req`  in  1  scan-out read request
- `vga_addr`  in  ADDR_W  scan-out address
- `vga_rdata`  out  DATA_W  scan-out data
- `vga_valid`  out  1  `vga_rdata` valid
- `ram_addr`  out  ADDR_W  VRAM address
- `ram_wdata`  out  DATA_W  VRAM write data
- `ram_we`  out  1  VRAM write enable
- `ram_rdata`  in  DATA_W  VRAM read data, one cycle after address

## Operation
- One VRAM access per cycle. Grant priority: `vga_req` first, then the CPU read issue, then the FIFO drain.
- **Write posting**
  - If `cpu_we` is high and the FIFO is not full: push `{cpu_addr, cpu_wdata}` and keep `cpu_hold` low.
  - If the FIFO is full: `cpu_hold` is high. A same-cycle drain does not free the slot for that cycle's push; the push happens in the first cycle that starts not-full.
- **Drain:** pop the head entry when it is granted, with `ram_we`=1 and `ram_addr`/`ram_wdata` taken from the head. Writes are drained strictly in FIFO order.
- **Read FSM, states `IDLE`, `RD_DATA`, `RD_DONE`**
  - `IDLE`: if `cpu_re` is high, the FIFO is empty and `vga_req` is low, issue `ram_addr`=`cpu_addr` and go to `RD_DATA`. Otherwise stay. This ordering guarantees read-after-write consistency.
  - `RD_DATA`: capture `ram_rdata` into the `cpu_rdata` register and go to `RD_DONE`. `vga_req` is not granted in this cycle; it is granted the following cycle.
  - `RD_DONE`: go to `IDLE` unconditionally. The `cpu_re` still asserted here belongs to the same `lw` and is not reissued.
- `cpu_hold` = (`cpu_re` and state≠`RD_DONE`) or (`cpu_we` and FIFO full).
- **Illegal input:** `cpu_we` and `cpu_re` both high. The write is taken and the read is ignored for that cycle.
- **VGA path:** a grant in cycle N gives `vga_valid`=1 in N+1, with `vga_rdata`=`ram_rdata`. A request in an `RD_DATA` cycle slips one cycle.
- **FIFO pointers:** wrap modulo `FIFO_DEPTH`. A count of 0..`FIFO_DEPTH` gives the full and empty flags.
- **No-access cycles:** with no grant, `ram_we`=0 and `ram_addr` holds its last value.

## Timing
- **Reset values:** state `IDLE`, FIFO empty (pending writes are discarded), `cpu_rdata`=0, `vga_valid`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0.
- **`cpu_hold` during reset:** forced to 0 while `rst` is high.
- **Uncontended read:** `cpu_hold` is high for exactly 2 cycles (issue, capture). Data is presented in the third cycle, when `cpu_hold` is low.
- **Read stretching:** each pending FIFO entry and each granted VGA cycle ahead of the issue adds one hold cycle.
- **Posted write:** zero CPU latency. The VRAM write occurs at the earliest 1 cycle after the push; a push and a drain of the same entry never happen in one cycle.
- **Reset in `RD_DATA` or `RD_DONE`:** next state `IDLE`, and the captured data is discarded.

## Structure
- **Package `vram_arb_pkg`:** the state enum (`IDLE`, `RD_DATA`, `RD_DONE`), the default `ADDR_W`/`DATA_W`/`FIFO_DEPTH`, and the FIFO entry struct `{addr, data}`.
- **Sub-module `wr_post_fifo`:** a synchronous FIFO with `push`, `pop`, `full`, `empty`, `head` and a synchronous active-high reset. The arbiter, the FSM and the hold logic stay in `vram_arbiter`.

## Test plan
- **Reset:** assert `rst` for 2 cycles with `cpu_re`=1 and `vga_req`=1. Required: `cpu_hold`=0, `ram_we`=0, `vga_valid`=0 throughout, and the FIFO is empty after release.
- **Posted writes:** write 0xA0..0xA3 to 0x010..0x013 on consecutive cycles, with no VGA traffic. Required: `cpu_hold` is never high, and `ram_we` pulses for addresses 0x010..0x013 in order, each one cycle after its push.
- **Full FIFO under VGA load:** hold `vga_req`=1 for 6 cycles while the CPU writes 5 words. Required: the 5th write holds until the first cycle after the FIFO is no longer full, `vga_valid` follows each request by 1 cycle, and drain order is preserved.
- **Read-after-write:** write 0x1234 to 0x020, then read 0x020 on the next cycle. Required: `cpu_hold`=1 for exactly 3 cycles, then `cpu_rdata`=0x1234 with `cpu_hold`=0.
- **Read with VGA contention:** `cpu_re` with an empty FIFO while `vga_req`=1 for 2 cycles. Required: `cpu_hold` is high for 4 cycles, and both VGA reads return valid data.
- **Reset mid-read:** assert `rst` in `RD_DATA`. Required: the next state is `IDLE`, `cpu_hold`=0 during reset, and a fresh read afterwards completes in 2 hold cycles.
